// File: rtl/ifu_fetch.sv
// ifu_fetch - instruction-fetch stage in front of the RV32I execute core.
//
// Takes one fetch PC at a time from the core, issues a single read on the memory
// address/data handshake and returns the instruction word with an error flag.
// Misaligned PCs, non-OK read responses and read timeouts all return inst_err=1, inst=0.
// All outputs are registered.
//
// Optional feature: define IFU_LASTHIT_EN to add a one-entry {valid, pc, word} buffer
// that answers a repeated fetch of the last successfully read PC without a bus access.
//
// Ports:
//   clk, reset                  clock; synchronous active-high reset
//   fetch_valid/ready, fetch_pc core -> IFU fetch request
//   flush                       drop in-flight fetch, invalidate buffer
//   mem_ar*                     read address channel (request)
//   mem_r*                      read data channel (rresp 00 = OK)
//   inst_valid/ready, inst,     IFU -> core instruction, its PC and error flag
//   inst_pc, inst_err
module ifu_fetch #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 255,  // 0 disables the read timeout
    parameter int unsigned CNT_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_valid,
    output logic              fetch_ready,
    input  logic [ADDR_W-1:0] fetch_pc,
    input  logic              flush,
    output logic              mem_arvalid,
    input  logic              mem_arready,
    output logic [ADDR_W-1:0] mem_araddr,
    input  logic              mem_rvalid,
    output logic              mem_rready,
    input  logic [31:0]       mem_rdata,
    input  logic [1:0]        mem_rresp,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_err
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

    // Counter value seen in the last WAIT cycle before the timeout fires.
    localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT - 1);

    state_e             state_q, state_d;
    logic               drop_q, drop_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  araddr_d, inst_pc_d;
    logic [31:0]        inst_d;
    logic               inst_err_d;
    logic               timeout_hit;

`ifdef IFU_LASTHIT_EN
    logic               lh_valid_q, lh_valid_d;
    logic [ADDR_W-1:0]  lh_pc_q, lh_pc_d;
    logic [31:0]        lh_word_q, lh_word_d;
`endif

    always_comb begin
        timeout_hit = (TIMEOUT != 0) && (cnt_q == TimeoutLast);
    end

    always_comb begin
        state_d    = state_q;
        drop_d     = drop_q;
        cnt_d      = cnt_q;
        araddr_d   = mem_araddr;
        inst_pc_d  = inst_pc;
        inst_d     = inst;
        inst_err_d = inst_err;
`ifdef IFU_LASTHIT_EN
        lh_valid_d = lh_valid_q;
        lh_pc_d    = lh_pc_q;
        lh_word_d  = lh_word_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (fetch_valid && !flush) begin
                    inst_pc_d = fetch_pc;
                    if (fetch_pc[1:0] != 2'b00) begin
                        inst_d     = '0;
                        inst_err_d = 1'b1;
                        state_d    = StResp;
`ifdef IFU_LASTHIT_EN
                    end else if (lh_valid_q && (lh_pc_q == fetch_pc)) begin
                        inst_d     = lh_word_q;
                        inst_err_d = 1'b0;
                        state_d    = StResp;
`endif
                    end else begin
                        araddr_d = fetch_pc;
                        state_d  = StReq;
                    end
                end
            end
            StReq: begin
                // An issued request cannot be withdrawn; remember to discard its response.
                if (flush) drop_d = 1'b1;
                if (mem_arready) begin
                    cnt_d   = '0;
                    state_d = StWait;
                end
            end
            StWait: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (mem_rvalid || timeout_hit) begin
                    if (drop_q || flush) begin
                        drop_d  = 1'b0;
                        state_d = StIdle;
                    end else begin
                        state_d = StResp;
                        if (mem_rvalid) begin
                            inst_err_d = (mem_rresp != 2'b00);
                            inst_d     = (mem_rresp == 2'b00) ? mem_rdata : 32'h0;
`ifdef IFU_LASTHIT_EN
                            if (mem_rresp == 2'b00) begin
                                lh_valid_d = 1'b1;
                                lh_pc_d    = inst_pc;
                                lh_word_d  = mem_rdata;
                            end
`endif
                        end else begin
                            inst_d     = '0;
                            inst_err_d = 1'b1;
                        end
                    end
                end else if (flush) begin
                    drop_d = 1'b1;
                end
            end
            StResp: begin
                if (flush || inst_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

`ifdef IFU_LASTHIT_EN
        if (flush) lh_valid_d = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            drop_q      <= 1'b0;
            cnt_q       <= '0;
            fetch_ready <= 1'b1;
            mem_arvalid <= 1'b0;
            mem_rready  <= 1'b0;
            inst_valid  <= 1'b0;
            inst_err    <= 1'b0;
            inst        <= '0;
            inst_pc     <= '0;
            mem_araddr  <= '0;
        end else begin
            state_q     <= state_d;
            drop_q      <= drop_d;
            cnt_q       <= cnt_d;
            fetch_ready <= (state_d == StIdle);
            mem_arvalid <= (state_d == StReq);
            mem_rready  <= (state_d == StWait);
            inst_valid  <= (state_d == StResp);
            inst_err    <= inst_err_d;
            inst        <= inst_d;
            inst_pc     <= inst_pc_d;
            mem_araddr  <= araddr_d;
        end
    end

`ifdef IFU_LASTHIT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            lh_valid_q <= 1'b0;
            lh_pc_q    <= '0;
            lh_word_q  <= '0;
        end else begin
            lh_valid_q <= lh_valid_d;
            lh_pc_q    <= lh_pc_d;
            lh_word_q  <= lh_word_d;
        end
    end
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Testbench for ifu_fetch (TIMEOUT=4). Reference model: per-fetch latency and result are
// computed from the handshake delays chosen by the bench; a {valid, pc, word} record models
// the last-hit buffer when IFU_LASTHIT_EN is defined.
module tb_ifu_fetch;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned TIMEOUT = 4;
    localparam int unsigned CNT_W   = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              fetch_valid, fetch_ready, flush;
    logic [ADDR_W-1:0] fetch_pc, mem_araddr, inst_pc;
    logic              mem_arvalid, mem_arready, mem_rvalid, mem_rready;
    logic [31:0]       mem_rdata, inst;
    logic [1:0]        mem_rresp;
    logic              inst_valid, inst_ready, inst_err;

    int checks = 0;
    int failures = 0;

    // Model of the last-hit buffer.
    bit          m_valid = 1'b0;
    logic [31:0] m_pc = '0;
    logic [31:0] m_word = '0;

    ifu_fetch #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_pc(fetch_pc),
        .flush(flush),
        .mem_arvalid(mem_arvalid), .mem_arready(mem_arready), .mem_araddr(mem_araddr),
        .mem_rvalid(mem_rvalid), .mem_rready(mem_rready), .mem_rdata(mem_rdata),
        .mem_rresp(mem_rresp),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
        .inst_err(inst_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
        m_valid = 1'b0;
    endtask

    // One complete fetch: the model predicts latency/result, the bench plays memory.
    task automatic run_fetch(input logic [31:0] pc, input int ar_dly, input int r_dly,
                             input logic [31:0] rdata, input logic [1:0] rresp,
                             input string name);
        bit mis, hit, exp_bus, saw_ar, addr_bad, done;
        int exp_lat, lat, ar_cnt, r_cnt, waitc;
        logic [31:0] exp_inst;
        logic exp_err;
        mis = (pc[1:0] != 2'b00);
`ifdef IFU_LASTHIT_EN
        hit = !mis && m_valid && (m_pc == pc);
`else
        hit = 1'b0;
`endif
        if (mis) begin
            exp_lat = 1; exp_inst = '0; exp_err = 1'b1; exp_bus = 1'b0;
        end else if (hit) begin
            exp_lat = 1; exp_inst = m_word; exp_err = 1'b0; exp_bus = 1'b0;
        end else begin
            exp_bus = 1'b1;
            if (r_dly < int'(TIMEOUT)) begin
                exp_lat  = ar_dly + 3 + r_dly;
                exp_err  = (rresp != 2'b00);
                exp_inst = exp_err ? 32'h0 : rdata;
                if (!exp_err) begin
                    m_valid = 1'b1; m_pc = pc; m_word = rdata;
                end
            end else begin
                exp_lat = ar_dly + 2 + int'(TIMEOUT); exp_inst = '0; exp_err = 1'b1;
            end
        end

        waitc = 0;
        while (!fetch_ready && waitc < 20) begin
            step();
            waitc++;
        end
        fetch_valid = 1'b1;
        fetch_pc = pc;
        step();
        fetch_valid = 1'b0;
        fetch_pc = $urandom;
        lat = 1; saw_ar = 0; addr_bad = 0; done = 0; ar_cnt = 0; r_cnt = 0;
        while (!done && lat < 60) begin
            if (inst_valid) begin
                done = 1;
            end else begin
                if (mem_arvalid) begin
                    saw_ar = 1;
                    if (mem_araddr !== pc) addr_bad = 1;
                    mem_arready = (ar_cnt == ar_dly);
                    ar_cnt++;
                end else begin
                    mem_arready = 1'b0;
                end
                if (mem_rready) begin
                    mem_rvalid = (r_cnt == r_dly);
                    mem_rdata  = (r_cnt == r_dly) ? rdata : $urandom;
                    mem_rresp  = rresp;
                    r_cnt++;
                end else begin
                    mem_rvalid = 1'b0;
                end
                step();
                lat++;
            end
        end
        mem_arready = 1'b0;

        checks++;
        if (!done) begin
            failures++;
            $display("FAIL %s: no inst_valid within %0d cycles (expected at %0d)",
                     name, lat, exp_lat);
            mem_rvalid = 1'b0;
            return;
        end
        if (lat !== exp_lat) begin
            failures++;
            $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
        end
        checks++;
        if ({inst_err, inst, inst_pc} !== {exp_err, exp_inst, pc}) begin
            failures++;
            $display("FAIL %s result: got err=%0b inst=%h pc=%h want err=%0b inst=%h pc=%h",
                     name, inst_err, inst, inst_pc, exp_err, exp_inst, pc);
        end
        checks++;
        if ({saw_ar, addr_bad} !== {exp_bus, 1'b0}) begin
            failures++;
            $display("FAIL %s bus: got arvalid_seen=%0b addr_bad=%0b want %0b 0",
                     name, saw_ar, addr_bad, exp_bus);
        end

        // Hold inst_ready low while a stray late read response is offered.
        repeat ($urandom_range(1, 3)) begin
            mem_rvalid = 1'b1;
            mem_rdata  = $urandom;
            mem_rresp  = 2'b00;
            step();
            checks++;
            if ({inst_valid, mem_rready, inst_err, inst, inst_pc} !==
                {1'b1, 1'b0, exp_err, exp_inst, pc}) begin
                failures++;
                $display("FAIL %s hold: got v=%0b rready=%0b err=%0b inst=%h pc=%h",
                         name, inst_valid, mem_rready, inst_err, inst, inst_pc);
            end
        end
        mem_rvalid = 1'b0;
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        checks++;
        if ({inst_valid, fetch_ready} !== 2'b01) begin
            failures++;
            $display("FAIL %s consume: got inst_valid=%0b fetch_ready=%0b want 0 1",
                     name, inst_valid, fetch_ready);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if ({fetch_ready, mem_arvalid, mem_rready, inst_valid, inst_err} !== 5'b10000) begin
            failures++;
            $display("FAIL %s ctrl: got rdy/arv/rrdy/iv/err=%b want 10000", name,
                     {fetch_ready, mem_arvalid, mem_rready, inst_valid, inst_err});
        end
        checks++;
        if ({inst, inst_pc, mem_araddr} !== 96'h0) begin
            failures++;
            $display("FAIL %s data: got inst=%h pc=%h araddr=%h want 0", name,
                     inst, inst_pc, mem_araddr);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) step();
        check_reset_outputs("reset");
        reset = 1'b0;
        step();
        check_reset_outputs("after_reset");
    endtask

    task automatic test_directed();
        run_fetch(32'h8000_0000, 0, 0, 32'h0010_0093, 2'b00, "t1_basic");
        run_fetch(32'h8000_0002, 0, 0, 32'h0, 2'b00, "t2_misaligned");
        run_fetch(32'h8000_0020, 5, 1, 32'hdead_beef, 2'b10, "t3_slow_ar_buserr");
        run_fetch(32'h8000_0030, 0, 99, 32'h0, 2'b00, "t4_timeout");
        run_fetch(32'h8000_0034, 1, 3, 32'h1234_5678, 2'b00, "rvalid_last_wait_cycle");
    endtask

    task automatic test_flush();
        int bad;
        // Flush while waiting for data: response discarded.
        fetch_valid = 1'b1; fetch_pc = 32'h8000_0000;
        step();
        fetch_valid = 1'b0; mem_arready = 1'b1;
        step();
        mem_arready = 1'b0;
        checks++;
        if (mem_rready !== 1'b1) begin
            failures++;
            $display("FAIL flush_wait entry: got rready=%0b want 1", mem_rready);
        end
        pulse_flush();
        mem_rvalid = 1'b1; mem_rdata = 32'hcafe_f00d; mem_rresp = 2'b00;
        step();
        mem_rvalid = 1'b0;
        bad = 0;
        repeat (4) begin
            if (inst_valid !== 1'b0 || fetch_ready !== 1'b1) bad++;
            step();
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL flush_wait drop: got %0d bad cycles want 0", bad);
        end
        run_fetch(32'h8000_0004, 0, 0, 32'h0020_0113, 2'b00, "t5_after_flush");

        // Flush while the request is still pending: arvalid/araddr hold until accepted.
        fetch_valid = 1'b1; fetch_pc = 32'h8000_0008;
        step();
        fetch_valid = 1'b0;
        pulse_flush();
        bad = 0;
        repeat (2) begin
            if (mem_arvalid !== 1'b1 || mem_araddr !== 32'h8000_0008) bad++;
            step();
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL flush_req hold: got %0d bad cycles want 0", bad);
        end
        mem_arready = 1'b1;
        step();
        mem_arready = 1'b0; mem_rvalid = 1'b1;
        step();
        mem_rvalid = 1'b0;
        checks++;
        if ({inst_valid, fetch_ready} !== 2'b01) begin
            failures++;
            $display("FAIL flush_req drop: got iv=%0b rdy=%0b want 0 1", inst_valid, fetch_ready);
        end

        // Flush while presenting an instruction.
        fetch_valid = 1'b1; fetch_pc = 32'h8000_0001;
        step();
        fetch_valid = 1'b0;
        pulse_flush();
        checks++;
        if ({inst_valid, fetch_ready} !== 2'b01) begin
            failures++;
            $display("FAIL flush_resp: got iv=%0b rdy=%0b want 0 1", inst_valid, fetch_ready);
        end

        // Flush beats fetch_valid in the same cycle.
        fetch_valid = 1'b1; fetch_pc = 32'h8000_0040;
        pulse_flush();
        fetch_valid = 1'b0;
        checks++;
        if ({fetch_ready, mem_arvalid, inst_valid} !== 3'b100) begin
            failures++;
            $display("FAIL flush_priority: got rdy/arv/iv=%b want 100",
                     {fetch_ready, mem_arvalid, inst_valid});
        end
    endtask

    task automatic test_reset_midfetch();
        fetch_valid = 1'b1; fetch_pc = 32'h8000_0050;
        step();
        fetch_valid = 1'b0; mem_arready = 1'b1;
        step();
        mem_arready = 1'b0;
        reset = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
        step();
        reset = 1'b0;
        m_valid = 1'b0;
        check_reset_outputs("reset_midfetch");
        step();
        mem_rvalid = 1'b0;
        checks++;
        if ({inst_valid, mem_rready, fetch_ready} !== 3'b001) begin
            failures++;
            $display("FAIL reset_midfetch late: got iv/rrdy/rdy=%b want 001",
                     {inst_valid, mem_rready, fetch_ready});
        end
    endtask

    task automatic test_lasthit();
        run_fetch(32'h8000_0010, 0, 0, 32'h0030_0193, 2'b00, "t6_first");
        run_fetch(32'h8000_0010, 0, 0, 32'h0030_0193, 2'b00, "t6_repeat");
        pulse_flush();
        run_fetch(32'h8000_0010, 0, 0, 32'h0040_0213, 2'b00, "t6_after_flush");
    endtask

    task automatic test_back_to_back();
        logic [31:0] pcs [2];
        logic [31:0] words [3];
        int acc_cyc [2];
        int iv_cyc [2];
        int n_acc, n_iv, n_rsp;
        bit acc_now;
        pcs[0] = 32'h8000_0100; pcs[1] = 32'h8000_0104;
        words[0] = $urandom; words[1] = $urandom; words[2] = 32'h0;
        pulse_flush();
        n_acc = 0; n_iv = 0; n_rsp = 0;
        inst_ready = 1'b1; fetch_valid = 1'b1; fetch_pc = pcs[0];
        for (int c = 0; c < 14; c++) begin
            if (inst_valid && n_iv < 2) begin
                iv_cyc[n_iv] = c;
                checks++;
                if ({inst_err, inst, inst_pc} !== {1'b0, words[n_iv], pcs[n_iv]}) begin
                    failures++;
                    $display("FAIL b2b data%0d: got err=%0b inst=%h pc=%h want 0 %h %h", n_iv,
                             inst_err, inst, inst_pc, words[n_iv], pcs[n_iv]);
                end
                n_iv++;
            end
            acc_now = fetch_valid && fetch_ready;
            if (acc_now) acc_cyc[n_acc] = c;
            mem_arready = mem_arvalid;
            mem_rvalid  = mem_rready;
            mem_rresp   = 2'b00;
            mem_rdata   = words[n_rsp];
            if (mem_rready && n_rsp < 2) n_rsp++;
            step();
            if (acc_now) begin
                n_acc++;
                if (n_acc < 2) fetch_pc = pcs[n_acc];
                else fetch_valid = 1'b0;
            end
        end
        inst_ready = 1'b0; mem_arready = 1'b0; mem_rvalid = 1'b0;
        checks++;
        if (n_iv != 2 || n_acc != 2) begin
            failures++;
            $display("FAIL b2b count: got accepts=%0d insts=%0d want 2 2", n_acc, n_iv);
        end else begin
            checks++;
            if ({iv_cyc[0] - acc_cyc[0], iv_cyc[1] - iv_cyc[0], acc_cyc[1] - acc_cyc[0]} !==
                {32'sd3, 32'sd4, 32'sd4}) begin
                failures++;
                $display("FAIL b2b timing: got lat=%0d iv_gap=%0d acc_gap=%0d want 3 4 4",
                         iv_cyc[0] - acc_cyc[0], iv_cyc[1] - iv_cyc[0], acc_cyc[1] - acc_cyc[0]);
            end
        end
        m_valid = 1'b1; m_pc = pcs[1]; m_word = words[1];
    endtask

    task automatic test_random();
        logic [31:0] pool [4];
        logic [31:0] pc;
        logic [1:0]  rresp;
        pool[0] = 32'h8000_0200; pool[1] = 32'h8000_0204;
        pool[2] = 32'h8000_0300; pool[3] = 32'h0000_1000;
        for (int i = 0; i < 24; i++) begin
            pc = pool[$urandom_range(0, 3)];
            if ($urandom_range(0, 7) == 0) pc = pc | 32'($urandom_range(1, 3));
            rresp = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            if ($urandom_range(0, 9) == 0) pulse_flush();
            run_fetch(pc, $urandom_range(0, 3), $urandom_range(0, 5), $urandom, rresp,
                      $sformatf("rand%0d", i));
        end
    endtask

    initial begin
        reset = 1'b1;
        fetch_valid = 1'b0; fetch_pc = '0; flush = 1'b0;
        mem_arready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_rresp = '0;
        inst_ready = 1'b0;
        test_reset();
        test_directed();
        test_flush();
        test_reset_midfetch();
        test_lasthit();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1);
    end
endmodule
